sdcard_dma_sched: RTL and testbench

Schedules 512-byte SD-card sector DMA bursts between the two sector-buffer consumers: the IDE sector buffer and the CDDA audio ring.
- Sits between the requesters and the sdcard_interface DMA stream (dma_data/dma_addr/dma_strobe).
- Arbitrates requests, issues one start pulse per sector and steers strobes to exactly one consumer.
- Checks burst integrity and reports completion or error per grant.

---
 rtl/sdcard_dma_sched_pkg.sv | 16 +
 rtl/sdcard_dma_sched_arb.sv | 26 ++
 rtl/sdcard_dma_sched.sv | 139 +++++++++++++
 tb/tb_sdcard_dma_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sdcard_dma_sched_pkg.sv
// Shared encodings for the SD-card sector DMA scheduler and its arbiter.
package sdcard_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic OWN_IDE  = 1'b0;
  localparam logic OWN_CDDA = 1'b1;

  localparam int SECTOR_BYTES_DEF = 512;

endpackage

// File: rtl/sdcard_dma_sched_arb.sv
// Two-way round-robin arbiter with CDDA urgent override; bit 0 = IDE, bit 1 = CDDA.
module dma_rr_arb2
  import sdcard_dma_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       urgent_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       valid_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[OWN_CDDA] && urgent_i) begin
      gnt_o = 2'b10;
    end else if (&req_i) begin
      // Both pending: hand the sector to whoever did not get the last one.
      gnt_o = (last_i == OWN_CDDA) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/sdcard_dma_sched.sv
// Schedules 512-byte SD sector bursts between the IDE buffer and the CDDA ring,
// steering DMA strobes to the owner and checking burst integrity.
module sdcard_dma_sched
  import sdcard_dma_pkg::*;
#(
  parameter int SECTOR_BYTES   = SECTOR_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMR_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ide_req,
  input  logic       cdda_req,
  input  logic       cdda_urgent,
  output logic       sd_start,
  input  logic       sd_busy,
  input  logic       dma_strobe,
  input  logic [8:0] dma_addr,
  output logic       ide_dma_en,
  output logic       cdda_dma_en,
  output logic       ide_done,
  output logic       cdda_done,
  output logic       xfer_err,
  output logic       busy
);

  localparam logic [9:0]       CNT_END  = 10'(SECTOR_BYTES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic             owner_q, last_q;
  logic [9:0]       cnt_q;
  logic [TMR_W-1:0] tmr_q;
  logic             sd_start_q, ide_en_q, cdda_en_q;
  logic             ide_done_q, cdda_done_q, err_q, busy_q;

  logic [1:0] arb_gnt;
  logic       arb_valid;
  logic [9:0] cnt_inc;
  logic       fin_d, ferr_d;

  dma_rr_arb2 u_arb (
    .req_i   ({cdda_req, ide_req}),
    .urgent_i(cdda_urgent),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  assign cnt_inc = cnt_q + 10'd1;

  // Burst termination: address mismatch, last byte accepted, or strobe gap timeout.
  always_comb begin
    fin_d  = 1'b0;
    ferr_d = 1'b0;
    if (state_q == S_XFER) begin
      if (dma_strobe) begin
        if (dma_addr != cnt_q[8:0]) begin
          fin_d  = 1'b1;
          ferr_d = 1'b1;
        end else if (cnt_inc == CNT_END) begin
          fin_d = 1'b1;
        end
      end else if (tmr_q == TMR_LAST) begin
        fin_d  = 1'b1;
        ferr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IDE;
      last_q      <= OWN_CDDA;
      cnt_q       <= '0;
      tmr_q       <= '0;
      sd_start_q  <= 1'b0;
      ide_en_q    <= 1'b0;
      cdda_en_q   <= 1'b0;
      ide_done_q  <= 1'b0;
      cdda_done_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sd_start_q  <= 1'b0;
      ide_done_q  <= 1'b0;
      cdda_done_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!sd_busy && arb_valid) begin
            owner_q    <= arb_gnt[1];
            last_q     <= arb_gnt[1];
            sd_start_q <= 1'b1;
            ide_en_q   <= arb_gnt[0];
            cdda_en_q  <= arb_gnt[1];
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          cnt_q   <= '0;
          tmr_q   <= '0;
          state_q <= S_XFER;
        end
        S_XFER: begin
          if (fin_d) begin
            ide_en_q    <= 1'b0;
            cdda_en_q   <= 1'b0;
            ide_done_q  <= (owner_q == OWN_IDE);
            cdda_done_q <= (owner_q == OWN_CDDA);
            err_q       <= ferr_d;
            state_q     <= S_DONE;
          end else if (dma_strobe) begin
            cnt_q <= cnt_inc;
            tmr_q <= '0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sd_start    = sd_start_q;
  assign ide_dma_en  = ide_en_q;
  assign cdda_dma_en = cdda_en_q;
  assign ide_done    = ide_done_q;
  assign cdda_done   = cdda_done_q;
  assign xfer_err    = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sdcard_dma_sched.sv
// Directed bench for sdcard_dma_sched: table of arbitration bursts plus
// hand-written error, timeout, gating and reset sequences.
module tb_sdcard_dma_sched;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst, ide_req, cdda_req, cdda_urgent, sd_busy, dma_strobe;
  logic [8:0] dma_addr;
  logic       sd_start, ide_dma_en, cdda_dma_en, ide_done, cdda_done, xfer_err, busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdcard_dma_sched #(
    .SECTOR_BYTES  (512),
    .TIMEOUT_CYCLES(TMO),
    .TMR_W         (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ide_req    (ide_req),
    .cdda_req   (cdda_req),
    .cdda_urgent(cdda_urgent),
    .sd_start   (sd_start),
    .sd_busy    (sd_busy),
    .dma_strobe (dma_strobe),
    .dma_addr   (dma_addr),
    .ide_dma_en (ide_dma_en),
    .cdda_dma_en(cdda_dma_en),
    .ide_done   (ide_done),
    .cdda_done  (cdda_done),
    .xfer_err   (xfer_err),
    .busy       (busy)
  );

  typedef struct {
    logic ide;
    logic cdda;
    logic urg;
    logic drop;
    logic exp_own;  // 0 = IDE, 1 = CDDA
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] all_outs();
    return {sd_start, ide_dma_en, cdda_dma_en, ide_done, cdda_done, xfer_err, busy};
  endfunction

  // mode: 0 full sector, 1 bad address at strobe bad_idx, 2 timeout,
  //       3 timeout with one strobe in XFER cycle 99, 4 reset after bad_idx bytes
  task automatic burst(input string tag, input logic ide, input logic cdda, input logic urg,
                       input logic drop, input int mode, input int bad_idx, input logic exp_own);
    int         cyc;
    int         n;
    logic       mon_bad;
    logic [1:0] exp_pair;
    exp_pair     = exp_own ? 2'b01 : 2'b10;  // {ide, cdda}
    mon_bad      = 1'b0;
    ide_req      = ide;
    cdda_req     = cdda;
    cdda_urgent  = urg;
    sd_busy      = 1'b0;
    dma_strobe   = 1'b0;
    cyc          = 1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (sd_start) break;
      if (cyc > 20) begin
        chk({tag, " start_timeout"}, cyc, 2);
        return;
      end
    end
    chk({tag, " start_lat"}, cyc, 2);
    chk({tag, " owner_en"}, {ide_dma_en, cdda_dma_en}, exp_pair);
    if (drop) begin
      ide_req  = 1'b0;
      cdda_req = 1'b0;
    end
    @(negedge clk);
    chk({tag, " start_pulse"}, sd_start, 0);

    if (mode <= 1 || mode == 4) begin
      n = (mode == 0) ? 512 : (mode == 1) ? bad_idx + 1 : bad_idx;
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        if ((ide_dma_en && cdda_dma_en) || ({ide_dma_en, cdda_dma_en} != exp_pair) ||
            ide_done || cdda_done)
          mon_bad = 1'b1;
        dma_strobe = 1'b1;
        dma_addr   = (mode == 1 && i == bad_idx) ? 9'(bad_idx + 2) : 9'(i);
      end
      @(negedge clk);
      dma_strobe = 1'b0;
      chk({tag, " en_monitor"}, mon_bad, 0);
      if (mode == 4) begin
        rst = 1'b1;
        @(negedge clk);
        chk({tag, " reset_outs"}, all_outs(), 0);
        rst      = 1'b0;
        ide_req  = 1'b0;
        cdda_req = 1'b0;
        mon_bad  = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (ide_done || cdda_done || busy) mon_bad = 1'b1;
        end
        chk({tag, " no_done_after_reset"}, mon_bad, 0);
        return;
      end
    end else begin
      cyc = 1;
      while (!(ide_done || cdda_done) && cyc <= 300) begin
        if (mode == 3 && cyc == 99) begin
          dma_strobe = 1'b1;
          dma_addr   = 9'd0;
        end else begin
          dma_strobe = 1'b0;
        end
        if ({ide_dma_en, cdda_dma_en} != exp_pair) mon_bad = 1'b1;
        @(negedge clk);
        cyc++;
      end
      dma_strobe = 1'b0;
      chk({tag, " timeout_cycles"}, cyc, (mode == 2) ? TMO + 1 : 2 * TMO);
      chk({tag, " en_monitor"}, mon_bad, 0);
    end

    chk({tag, " done_pair"}, {ide_done, cdda_done}, exp_pair);
    chk({tag, " xfer_err"}, xfer_err, (mode == 0) ? 0 : 1);
    chk({tag, " en_off_at_done"}, {ide_dma_en, cdda_dma_en}, 0);
    @(negedge clk);
    chk({tag, " idle_gap"}, {busy, ide_done, cdda_done}, 0);
  endtask

  initial begin
    rst         = 1'b1;
    ide_req     = 1'b0;
    cdda_req    = 1'b0;
    cdda_urgent = 1'b0;
    sd_busy     = 1'b0;
    dma_strobe  = 1'b0;
    dma_addr    = '0;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", all_outs(), 0);

    for (int v = 0; v < 9; v++) begin
      burst($sformatf("vec%0d", v), vecs[v].ide, vecs[v].cdda, vecs[v].urg, vecs[v].drop,
            0, 0, vecs[v].exp_own);
    end

    burst("addr_mismatch", 1'b1, 1'b0, 1'b0, 1'b0, 1, 5, 1'b0);
    burst("timeout", 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 1'b1);
    burst("timeout_restart", 1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0);

    ide_req  = 1'b1;
    cdda_req = 1'b0;
    sd_busy  = 1'b1;
    begin
      logic held_bad;
      held_bad = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (sd_start || busy) held_bad = 1'b1;
      end
      chk("sd_busy_hold", held_bad, 0);
    end
    burst("after_busy", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

    // Preceding burst went to IDE; reset must bring last_grant back to CDDA.
    burst("reset_mid", 1'b0, 1'b1, 1'b0, 1'b0, 4, 300, 1'b1);
    burst("post_reset", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
